// File: rtl/half_div_ctrl.sv
// Fractional clock divider: divides clk_in by N or N+0.5, with frame-aligned
// configuration switching and a glitch-free stop/restart sequence.
module half_div_ctrl #(
    parameter int CW       = 4,
    parameter int DEF_N    = 5,
    parameter bit DEF_HALF = 1'b1
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic          en,
    input  logic          cfg_valid,
    input  logic [CW-1:0] cfg_n,
    input  logic          cfg_half,
    output logic          cfg_ready,
    output logic          cfg_err,
    output logic          clk_out,
    output logic          frame_tick
);

    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PEND = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    localparam logic [CW-1:0] MIN_N    = CW'(2);
    localparam logic [CW-1:0] MAX_N    = {1'b0, {(CW-1){1'b1}}};
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] DEF_N_V  = CW'(DEF_N);

    logic [1:0]    state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [CW-1:0] act_n, act_n_d, pend_n, pend_n_d;
    logic          act_half, act_half_d, pend_half, pend_half_d;
    logic          stop_req, stop_d;
    logic          p_q, p_d, n_q, n_d;
    logic [CW-1:0] last;
    logic          at_last, cfg_legal, cfg_accept;

    // 2*N never overflows CW bits because legal N stays below 2^(CW-1).
    assign last    = act_half ? {act_n[CW-2:0], 1'b0} : act_n - ONE;
    assign at_last = (cnt == last);

    assign cfg_legal  = (cfg_n >= MIN_N) && (cfg_n <= MAX_N);
    assign cfg_ready  = rst_n && ((state == S_OFF) || (state == S_RUN));
    assign cfg_accept = cfg_valid && cfg_ready && cfg_legal;
    assign cfg_err    = cfg_valid && cfg_ready && !cfg_legal;
    assign frame_tick = (state != S_OFF) && (cnt == '0);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statement can infer a latch.
        state_d     = state;
        act_n_d     = act_n;
        act_half_d  = act_half;
        pend_n_d    = pend_n;
        pend_half_d = pend_half;
        stop_d      = stop_req;

        case (state)
            S_OFF: begin
                if (cfg_accept) begin
                    act_n_d    = cfg_n;
                    act_half_d = cfg_half;
                end
                if (en) state_d = S_RUN;
            end
            S_RUN: begin
                if (cfg_accept) begin
                    pend_n_d    = cfg_n;
                    pend_half_d = cfg_half;
                    stop_d      = !en;
                    state_d     = S_PEND;
                end else if (!en) begin
                    state_d = at_last ? S_OFF : S_STOP;
                end
            end
            S_PEND: begin
                stop_d = stop_req || !en;
                if (at_last) begin
                    act_n_d    = pend_n;
                    act_half_d = pend_half;
                    state_d    = stop_d ? S_STOP : S_RUN;
                    stop_d     = 1'b0;
                end
            end
            default: begin
                if (en)           state_d = S_RUN;
                else if (at_last) state_d = S_OFF;
            end
        endcase

        if (state_d == S_OFF || state == S_OFF || at_last) cnt_d = '0;
        else                                                cnt_d = cnt + ONE;

        // The posedge flop covers the whole cycle(s) the output may be high;
        // the negedge flop trims half-mode pulses to half a clk_in period.
        if (state_d == S_OFF)
            p_d = 1'b0;
        else if (act_half_d)
            p_d = (cnt_d == '0) || (cnt_d == act_n_d);
        else
            p_d = cnt_d < (act_n_d >> 1);
    end

    // Opens the gate from the falling edge before a pulse-A cycle and from the
    // falling edge of the pulse-B cycle; held open in integer mode.
    assign n_d = !act_half || (state == S_OFF) || (cnt == act_n) || at_last;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_OFF;
            cnt       <= '0;
            act_n     <= DEF_N_V;
            act_half  <= DEF_HALF;
            pend_n    <= DEF_N_V;
            pend_half <= DEF_HALF;
            stop_req  <= 1'b0;
            p_q       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values of its neighbours.
            state     <= state_d;
            cnt       <= cnt_d;
            act_n     <= act_n_d;
            act_half  <= act_half_d;
            pend_n    <= pend_n_d;
            pend_half <= pend_half_d;
            stop_req  <= stop_d;
            p_q       <= p_d;
        end
    end

    always_ff @(negedge clk_in or negedge rst_n) begin
        if (!rst_n) n_q <= 1'b0;
        else        n_q <= n_d;
    end

    // Both inputs change on opposite clock edges, so no output phase can be
    // shorter than half a clk_in period.
    assign clk_out = p_q & n_q;

endmodule

// File: tb/tb_half_div_ctrl.sv
// Directed self-checking bench for half_div_ctrl at CW=4, 20-unit clk_in period.
module tb_half_div_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [3:0] cfg_n = 4'd0;
    logic       cfg_half = 1'b0;
    logic       cfg_ready, cfg_err, clk_out, frame_tick;

    int errors = 0;
    int checks = 0;

    longint last_rise = 0, last_fall = 0, period = 0, high_w = 0;
    longint last_tick = 0, tick_gap = 0;
    int     rise_cnt = 0, runt_cnt = 0;

    always #10 clk_in = ~clk_in;

    half_div_ctrl #(.CW(4), .DEF_N(5), .DEF_HALF(1'b1)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_n      (cfg_n),
        .cfg_half   (cfg_half),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .clk_out    (clk_out),
        .frame_tick (frame_tick)
    );

    always @(posedge clk_out) begin
        if (rst_n && (longint'($time) - last_fall) < 10) runt_cnt++;
        period    = longint'($time) - last_rise;
        last_rise = longint'($time);
        rise_cnt++;
    end

    always @(negedge clk_out) begin
        high_w = longint'($time) - last_rise;
        if (rst_n && high_w < 10) runt_cnt++;
        last_fall = longint'($time);
    end

    always @(negedge clk_in) begin
        if (frame_tick) begin
            tick_gap  = longint'($time) - last_tick;
            last_tick = longint'($time);
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic wait_rises(input int n);
        int target;
        int cyc;
        target = rise_cnt + n;
        cyc    = 0;
        while (rise_cnt < target && cyc < 100) begin
            @(posedge clk_in);
            cyc++;
        end
        #1;
        if (rise_cnt < target) check("rise_wait", rise_cnt, target);
    endtask

    // Returns one unit after the falling edge of a cycle with cnt==0.
    task automatic wait_tick();
        int cyc;
        cyc = 0;
        do begin
            @(posedge clk_in);
            #1;
            cyc++;
        end while (!frame_tick && cyc < 60);
        if (!frame_tick) check("tick_wait", frame_tick, 1);
        @(negedge clk_in);
        #1;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    int r0;

    initial begin
        // Reset state
        #5;
        check("rst_clk_out", clk_out, 0);
        check("rst_tick", frame_tick, 0);
        check("rst_err", cfg_err, 0);
        repeat (3) @(posedge clk_in);
        #5 rst_n = 1'b1;
        #1;
        check("rst_ready", cfg_ready, 1);

        // Defaults N=5 half: period 110, width 10, frame every 11 cycles
        step();
        en = 1'b1;
        step();
        check("start_tick", frame_tick, 1);
        check("start_clk", clk_out, 1);
        wait_rises(4);
        check("def_period", period, 110);
        check("def_high", high_w, 10);
        wait_tick();
        wait_tick();
        check("def_frame", tick_gap, 220);

        // Illegal configurations rejected for one cycle each
        step();
        cfg_valid = 1'b1; cfg_n = 4'd1; cfg_half = 1'b1;
        #1;
        check("err_n1", cfg_err, 1);
        step();
        cfg_n = 4'd9;
        #1;
        check("err_n9", cfg_err, 1);
        step();
        cfg_valid = 1'b0;
        #1;
        check("err_clear", cfg_err, 0);
        check("err_ready", cfg_ready, 1);
        wait_rises(3);
        check("err_period", period, 110);

        // Switch to N=3 half at cnt==2: current frame 11, then 7 cycles
        wait_tick();
        step();
        step();
        cfg_valid = 1'b1; cfg_n = 4'd3; cfg_half = 1'b1;
        #1;
        check("sw_ready_pre", cfg_ready, 1);
        step();
        check("sw_ready_pend", cfg_ready, 0);
        cfg_n = 4'd1;
        #1;
        check("pend_no_err", cfg_err, 0);
        cfg_valid = 1'b0;
        wait_tick();
        check("sw_frame_old", tick_gap, 220);
        wait_tick();
        check("sw_frame_new", tick_gap, 140);
        wait_rises(2);
        check("sw_period", period, 70);
        check("sw_high", high_w, 10);

        // Drop en mid-frame: frame completes (one more rise), then OFF
        wait_tick();
        step();
        en = 1'b0;
        r0 = rise_cnt;
        step();
        check("stop_ready", cfg_ready, 0);
        repeat (20) step();
        check("stop_rises", rise_cnt - r0, 1);
        check("off_clk", clk_out, 0);
        check("off_tick", frame_tick, 0);
        check("off_ready", cfg_ready, 1);

        // Restart, then re-raise en inside STOP: no gap in frames
        en = 1'b1;
        wait_tick();
        wait_tick();
        step();
        en = 1'b0;
        step();
        en = 1'b1;
        wait_tick();
        check("restop_frame", tick_gap, 140);
        wait_rises(3);
        check("restop_period", period, 70);

        // Back to OFF, load N=4 integer while idle, then run
        step();
        en = 1'b0;
        repeat (20) step();
        check("off2_ready", cfg_ready, 1);
        check("off2_clk", clk_out, 0);
        cfg_valid = 1'b1; cfg_n = 4'd4; cfg_half = 1'b0;
        #1;
        check("int_no_err", cfg_err, 0);
        step();
        cfg_valid = 1'b0;
        en = 1'b1;
        step();
        check("int_start_clk", clk_out, 1);
        wait_rises(3);
        check("int_period", period, 80);
        check("int_high", high_w, 40);
        wait_tick();
        wait_tick();
        check("int_frame", tick_gap, 80);

        // Reset while PEND, off a clock edge: output drops, pending config lost
        wait_tick();
        cfg_valid = 1'b1; cfg_n = 4'd6; cfg_half = 1'b0;
        step();
        cfg_valid = 1'b0;
        check("pr_pend", cfg_ready, 0);
        check("pr_clk_hi", clk_out, 1);
        #4 rst_n = 1'b0;
        #1;
        check("pr_clk", clk_out, 0);
        check("pr_tick", frame_tick, 0);
        check("pr_err", cfg_err, 0);
        repeat (2) @(posedge clk_in);
        #5 rst_n = 1'b1;
        #1;
        check("pr_ready", cfg_ready, 1);
        step();
        check("pr_run_tick", frame_tick, 1);
        check("pr_run_clk", clk_out, 1);
        wait_rises(3);
        check("pr_period", period, 110);
        check("pr_high", high_w, 10);

        check("no_runt", runt_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/half_div_ctrl.md
HALF_DIV_CTRL -- requirements
Module: half_div_ctrl

Interface
REQ-001 Parameter CW, default 4: width of the frame counter and cfg_n.
REQ-002 Parameter DEF_N, default 5: divisor integer part loaded at reset.
REQ-003 Parameter DEF_HALF, default 1: half-mode flag loaded at reset.
REQ-004 clk_in  input  1  input clock; posedge domain, plus the negedge flop of REQ-014.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  run request; high = generate clock, low = stop after the current frame.
REQ-007 cfg_valid  input  1  new configuration offered.
REQ-008 cfg_n  input  CW  requested integer divisor N.
REQ-009 cfg_half  input  1  1 = divide by N+0.5, 0 = divide by N.
REQ-010 cfg_ready  output  1  block can accept a configuration.
REQ-011 cfg_err  output  1  one-cycle pulse: offered configuration rejected.
REQ-012 clk_out  output  1  divided clock.
REQ-013 frame_tick  output  1  one-cycle pulse in every clk_in cycle where cnt==0 while running.

Function
REQ-014 clk_out SHALL be built from exactly one posedge flop and one negedge flop combined by a single 2-input gate; clk_in SHALL NOT feed the gate directly.
REQ-015 Active config (act_n, act_half) SHALL come only from accepted configurations; legal N = 2..(2^(CW-1)-1), i.e. 2..7 at CW=4.
REQ-016 Frame counter cnt (posedge) SHALL count 0..L-1 then wrap to 0; L = 2*act_n+1 in half mode, L = act_n in integer mode.
REQ-017 Integer mode: clk_out high for the first floor(act_n/2) clk_in cycles of each frame (starting at the posedge with cnt==0), low for the rest; period = act_n cycles.
REQ-018 Half mode: two pulses per frame, each half a clk_in period wide -- pulse A = high phase of the cycle with cnt==0; pulse B = low phase of the cycle with cnt==act_n; output period = act_n+0.5 cycles.
REQ-019 FSM states: OFF, RUN, PEND (config waiting), STOP (draining to OFF).
REQ-020 OFF: cnt held 0, clk_out 0, frame_tick 0, cfg_ready 1; en=1 -> RUN next cycle, first frame starts with cnt==0.
REQ-021 RUN: cfg_ready 1; a legal handshake (cfg_valid & cfg_ready) -> PEND; en=0 -> STOP; handshake and en=0 in the same cycle -> PEND, with the stop request remembered.
REQ-022 PEND: cfg_ready 0; at the last cycle of the frame (cnt==L-1) the new config is loaded so the next frame uses it; then RUN, or STOP if a stop request is pending. A running clock SHALL never see a partial frame.
REQ-023 STOP: cfg_ready 0; on reaching cnt==L-1 -> OFF; en reasserted before then -> back to RUN with no gap.
REQ-024 Handshake in OFF SHALL load the config immediately (visible the next cycle).
REQ-025 Illegal cfg_n (<2 or above range) offered with cfg_ready=1: no state change, config unchanged, cfg_err=1 for exactly that cycle.
REQ-026 cfg_valid while cfg_ready=0 SHALL be ignored; there is no cfg_err in that case.
REQ-027 Frame boundaries SHALL be glitch-free: clk_out SHALL produce no pulse shorter than half a clk_in period across config switch or stop.

Reset
REQ-028 rst_n low, at any time and including mid-frame or in PEND, SHALL asynchronously force: state OFF, cnt 0, both output flops 0, clk_out 0, frame_tick 0, cfg_err 0, cfg_ready 1 after release, act_n = DEF_N, act_half = DEF_HALF, stop request cleared.
REQ-029 On the first posedge after rst_n rises with en=1, the FSM SHALL enter RUN.

Verification
REQ-030 Reset, en=1, defaults (N=5, half) -> clk_out has rising edges exactly 110 ns apart at a 20 ns clk_in; pulse width 10 ns; frame_tick every 11 cycles.
REQ-031 In OFF, offer cfg_n=4, cfg_half=0, then en=1 -> period 80 ns, high 40 ns; cfg_err never asserted.
REQ-032 While running N=5 half, offer N=3 half at cnt==2 -> cfg_ready drops, the current frame completes at 11 cycles, the following frames last 7 cycles, and no runt pulse appears.
REQ-033 Offer cfg_n=1 and cfg_n=9 (CW=4) -> cfg_err pulses for one cycle each; the period is unchanged.
REQ-034 Drop en mid-frame -> clk_out finishes the frame and then stays 0 in OFF; re-raise en in STOP -> continuous output.
REQ-035 Assert rst_n=0 while in PEND, off a clock edge -> clk_out goes 0 immediately and the pending config is discarded.
